host_cmd_initiator: RTL and testbench
=====================================

// Module: host_cmd_initiator
// PURPOSE
// - Initiator for the UART command protocol served by the system controller:
//   turns one command request into a byte frame for the UART TX path, then collects
//   the response bytes from the UART RX path.
// - Used as the host model/bridge in system tests and in the companion host-side block.
// - Frames (first byte = opcode):
//   WR   : AA, addr, data
//   RD   : BB, addr            -> 1 response byte
//   ALU  : CC, opA, opB, fun   -> 2 response bytes, LSB first
//   ALUN : DD, fun             -> 2 response bytes, LSB first
// PARAMETERS
// DATA_W       8     width of data/operand bytes (fixed at 8 by the frame format)
// ADDR_W       4     register-file address width; zero-extended to 8 bits on the wire
// TIMEOUT_CYC  4096  max cycles from last TX byte accepted to each expected response byte
// PORTS
// CLK          in   1         system clock
// RST          in   1         synchronous, active-high reset
// CMD_VALID    in   1         command request valid
// CMD_READY    out  1         initiator idle, can accept a command
// CMD_TYPE     in   2         0=WR 1=RD 2=ALU 3=ALUN
// CMD_ADDR     in   ADDR_W    register address (WR/RD)
// CMD_DATA     in   DATA_W    write data (WR)
// CMD_OPA      in   DATA_W    ALU operand A (ALU)
// CMD_OPB      in   DATA_W    ALU operand B (ALU)
// CMD_FUN      in   4         ALU function (ALU/ALUN)
// TX_DATA      out  8         frame byte to UART TX
// TX_VALID     out  1         TX_DATA valid; held with TX_DATA stable until TX_READY
// TX_READY     in   1         UART TX accepts byte this cycle
// RX_DATA      in   8         received byte from UART RX
// RX_VALID     in   1         one-cycle strobe, RX_DATA valid
// RSP_DATA     out  16        response: RD in [7:0] with [15:8]=0; ALU/ALUN as {MSB,LSB}
// RSP_VALID    out  1         one-cycle pulse; RSP_DATA valid; held until next response
// RSP_TIMEOUT  out  1         one-cycle pulse: response byte missing
// BEHAVIOUR
// - Reset: CMD_READY=1, TX_VALID=0, TX_DATA=0, RSP_DATA=0, RSP_VALID=0, RSP_TIMEOUT=0,
//   state IDLE, byte index and timer cleared.
// - Reset mid-operation aborts the frame at once. No partial byte is held.
// - FSM: IDLE -> SEND -> (WAIT_RSP | IDLE) ; WAIT_RSP -> IDLE.
// - IDLE:
//   - CMD_READY=1.
//   - On CMD_VALID, latch all CMD_* fields, drop CMD_READY and go to SEND.
//   - TX_VALID rises the next cycle with the opcode byte.
// - SEND:
//   - Byte index 0..len-1 (len: WR 3, RD 2, ALU 4, ALUN 2).
//   - On TX_VALID&&TX_READY, advance the index. The next byte is presented the following
//     cycle, so at most one byte is accepted per two cycles.
//   - After the last byte is accepted: TX_VALID=0.
//   - WR returns to IDLE (CMD_READY=1 next cycle). RD/ALU/ALUN go to WAIT_RSP with the
//     timer cleared.
// - WAIT_RSP:
//   - Expected bytes: RD 1, ALU/ALUN 2.
//   - Each RX_VALID stores RX_DATA (first=LSB, second=MSB) and reloads the timer.
//   - After the final byte: RSP_VALID pulses the next cycle, then IDLE.
//   - If the timer reaches TIMEOUT_CYC-1 with no RX_VALID: RSP_TIMEOUT pulses, RSP_DATA
//     is unchanged, then IDLE.
//   - RX_VALID in the same cycle as the timer expiry: the byte wins, no timeout.
// - RX_VALID in IDLE or SEND is ignored (no state change, no flag).
// - CMD_VALID while CMD_READY=0 is ignored; the requester holds it.
// - Timer width: $clog2(TIMEOUT_CYC). The timer saturates and never wraps.
// STRUCTURE
// - Shared package host_cmd_pkg:
//   - opcode constants OP_WR=8'hAA, OP_RD=8'hBB, OP_ALU=8'hCC, OP_ALUN=8'hDD
//   - CMD_TYPE encodings
//   - frame length and response count per type
// - Single module. The frame byte mux is a case on {type,index}.
// - No sub-module needed. Timer and FSM are inline.
// TESTING
// - WR addr=3 data=8'h5A, TX_READY=1 always
//   -> bytes AA,03,5A on consecutive accepts; CMD_READY back after 3rd accept;
//      no RSP_VALID.
// - RD addr=2, TX_READY stalled 5 cycles on byte 1
//   -> TX_DATA=02 held stable while stalled; RX 8'h7E
//   -> RSP_VALID with RSP_DATA=16'h007E.
// - ALU opA=8'h10 opB=8'h20 fun=0 -> AA-free frame CC,10,20,00; RX 30 then 00
//   -> RSP_DATA=16'h0030.
// - ALUN fun=4'h2, RX one byte only, TIMEOUT_CYC=16
//   -> RSP_TIMEOUT pulse 16 cycles after that byte; RSP_DATA unchanged; CMD_READY=1.
// - RST asserted mid ALU frame after byte 2
//   -> next cycle TX_VALID=0, CMD_READY=1; new RD frame runs cleanly.
// - RX_VALID during IDLE and SEND, plus RX in the expiry cycle
//   -> ignored in IDLE/SEND; expiry-cycle byte accepted, no RSP_TIMEOUT.

Source files
------------

// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host-side UART command protocol: opcodes, command
// type encodings, latched command payload and per-type frame/response sizes.
package host_cmd_pkg;

    localparam logic [7:0] OP_WR   = 8'hAA;
    localparam logic [7:0] OP_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU  = 8'hCC;
    localparam logic [7:0] OP_ALUN = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR   = 2'd0,
        CMD_RD   = 2'd1,
        CMD_ALU  = 2'd2,
        CMD_ALUN = 2'd3
    } cmd_type_e;

    // Command fields as they go on the wire (address already zero-extended).
    typedef struct packed {
        cmd_type_e  ctype;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] fun;
    } cmd_t;

    function automatic logic [7:0] opcode(input cmd_type_e t);
        case (t)
            CMD_WR:  opcode = OP_WR;
            CMD_RD:  opcode = OP_RD;
            CMD_ALU: opcode = OP_ALU;
            default: opcode = OP_ALUN;
        endcase
    endfunction

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        case (t)
            CMD_WR:  frame_len = 3'd3;
            CMD_RD:  frame_len = 3'd2;
            CMD_ALU: frame_len = 3'd4;
            default: frame_len = 3'd2;
        endcase
    endfunction

    function automatic logic [1:0] rsp_count(input cmd_type_e t);
        case (t)
            CMD_WR:  rsp_count = 2'd0;
            CMD_RD:  rsp_count = 2'd1;
            default: rsp_count = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_initiator.sv
// Host-side initiator: serialises one command into a UART TX byte frame and
// collects the response bytes from UART RX, with a per-byte response timeout.
module host_cmd_initiator
    import host_cmd_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_opa,
    input  logic [DATA_W-1:0] cmd_opb,
    input  logic [3:0]        cmd_fun,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       rsp_data,
    output logic              rsp_valid,
    output logic              rsp_timeout
);

    localparam int unsigned        TIMER_W   = $clog2(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [1:0]         idx_q, idx_d;
    logic               rx_idx_q, rx_idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         rx_lsb_q, rx_lsb_d;
    logic               cmd_ready_d, tx_valid_d, rsp_valid_d, rsp_timeout_d;
    logic [7:0]         tx_data_d, frame_byte;
    logic [15:0]        rsp_data_d;
    logic               last_byte, last_rx;

    assign last_byte = (3'(idx_q) + 3'd1) == frame_len(cmd_q.ctype);
    assign last_rx   = (2'(rx_idx_q) + 2'd1) == rsp_count(cmd_q.ctype);

    // Frame byte for the current type and byte index.
    always_comb begin
        frame_byte = 8'h00;
        case ({cmd_q.ctype, idx_q})
            {CMD_WR,   2'd0}: frame_byte = OP_WR;
            {CMD_WR,   2'd1}: frame_byte = cmd_q.addr;
            {CMD_WR,   2'd2}: frame_byte = cmd_q.data;
            {CMD_RD,   2'd0}: frame_byte = OP_RD;
            {CMD_RD,   2'd1}: frame_byte = cmd_q.addr;
            {CMD_ALU,  2'd0}: frame_byte = OP_ALU;
            {CMD_ALU,  2'd1}: frame_byte = cmd_q.opa;
            {CMD_ALU,  2'd2}: frame_byte = cmd_q.opb;
            {CMD_ALU,  2'd3}: frame_byte = {4'h0, cmd_q.fun};
            {CMD_ALUN, 2'd0}: frame_byte = OP_ALUN;
            {CMD_ALUN, 2'd1}: frame_byte = {4'h0, cmd_q.fun};
            default:          frame_byte = 8'h00;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        idx_d         = idx_q;
        rx_idx_d      = rx_idx_q;
        timer_d       = timer_q;
        rx_lsb_d      = rx_lsb_q;
        cmd_ready_d   = cmd_ready;
        tx_valid_d    = tx_valid;
        tx_data_d     = tx_data;
        rsp_data_d    = rsp_data;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.ctype = cmd_type_e'(cmd_type);
                    cmd_d.addr  = 8'(cmd_addr);
                    cmd_d.data  = 8'(cmd_data);
                    cmd_d.opa   = 8'(cmd_opa);
                    cmd_d.opb   = 8'(cmd_opb);
                    cmd_d.fun   = cmd_fun;
                    cmd_ready_d = 1'b0;
                    idx_d       = 2'd0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = opcode(cmd_type_e'(cmd_type));
                    state_d     = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_valid) begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        if (last_byte) begin
                            if (cmd_q.ctype == CMD_WR) begin
                                cmd_ready_d = 1'b1;
                                state_d     = S_IDLE;
                            end else begin
                                timer_d  = '0;
                                rx_idx_d = 1'b0;
                                state_d  = S_WAIT_RSP;
                            end
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end else begin
                    // Gap cycle after an accept: present the next byte.
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_byte;
                end
            end

            S_WAIT_RSP: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (rx_valid) begin
                    timer_d = '0;
                    if (last_rx) begin
                        rsp_data_d  = (cmd_q.ctype == CMD_RD) ? {8'h00, rx_data}
                                                              : {rx_data, rx_lsb_q};
                        rsp_valid_d = 1'b1;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rx_lsb_d = rx_data;
                        rx_idx_d = 1'b1;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    rsp_timeout_d = 1'b1;
                    cmd_ready_d   = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                tx_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            idx_q       <= 2'd0;
            rx_idx_q    <= 1'b0;
            timer_q     <= '0;
            rx_lsb_q    <= 8'h00;
            cmd_ready   <= 1'b1;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            rsp_data    <= 16'h0000;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            rx_idx_q    <= rx_idx_d;
            timer_q     <= timer_d;
            rx_lsb_q    <= rx_lsb_d;
            cmd_ready   <= cmd_ready_d;
            tx_valid    <= tx_valid_d;
            tx_data     <= tx_data_d;
            rsp_data    <= rsp_data_d;
            rsp_valid   <= rsp_valid_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_host_cmd_initiator.sv
// Self-checking bench for host_cmd_initiator: directed vector table, a mid-frame
// reset sequence and randomized commands checked against a frame/response model.
module tb_host_cmd_initiator;

    localparam int unsigned TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data, cmd_opa, cmd_opb;
    logic [3:0]  cmd_fun;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_timeout;

    host_cmd_initiator #(
        .DATA_W      (8),
        .ADDR_W      (4),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_opa     (cmd_opa),
        .cmd_opb     (cmd_opb),
        .cmd_fun     (cmd_fun),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_timeout (rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       ct;
        logic [3:0]       addr;
        logic [7:0]       data, opa, opb;
        logic [3:0]       fun;
        int               stall_idx, stall_n;
        logic             rand_stall, spur;
        int               n_rx;
        logic [7:0]       rx0, rx1;
        int               gap0, gap1;
        int               exp_len;
        logic [3:0][7:0]  ef;       // ef[0] is the first byte on the wire
        logic             exp_rsp;
        logic [15:0]      exp_data;
        logic             exp_to;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_rsp = 16'h0000;
    vec_t        vecs [7];
    vec_t        rv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] ct, input logic [3:0] addr, input logic [7:0] data,
        input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
        input int stall_idx, input int stall_n, input logic rand_stall, input logic spur,
        input int n_rx, input logic [7:0] rx0, input logic [7:0] rx1,
        input int gap0, input int gap1, input int exp_len, input logic [31:0] ef,
        input logic exp_rsp, input logic [15:0] exp_data, input logic exp_to);
        vec_t v;
        v.ct = ct; v.addr = addr; v.data = data; v.opa = opa; v.opb = opb; v.fun = fun;
        v.stall_idx = stall_idx; v.stall_n = stall_n; v.rand_stall = rand_stall; v.spur = spur;
        v.n_rx = n_rx; v.rx0 = rx0; v.rx1 = rx1; v.gap0 = gap0; v.gap1 = gap1;
        v.exp_len = exp_len; v.ef = ef; v.exp_rsp = exp_rsp; v.exp_data = exp_data;
        v.exp_to = exp_to;
        return v;
    endfunction

    // Reference model: frame contents and expected outcome straight from the protocol.
    task automatic model(inout vec_t v);
        int need;
        v.ef = '0;
        case (v.ct)
            2'd0: begin v.ef[0] = 8'hAA; v.ef[1] = {4'h0, v.addr}; v.ef[2] = v.data; v.exp_len = 3; need = 0; end
            2'd1: begin v.ef[0] = 8'hBB; v.ef[1] = {4'h0, v.addr}; v.exp_len = 2; need = 1; end
            2'd2: begin v.ef[0] = 8'hCC; v.ef[1] = v.opa; v.ef[2] = v.opb; v.ef[3] = {4'h0, v.fun};
                        v.exp_len = 4; need = 2; end
            default: begin v.ef[0] = 8'hDD; v.ef[1] = {4'h0, v.fun}; v.exp_len = 2; need = 2; end
        endcase
        v.exp_to   = (v.n_rx < need);
        v.exp_rsp  = (need > 0) && !v.exp_to;
        v.exp_data = (need == 1) ? {8'h00, v.rx0} : {v.rx1, v.rx0};
    endtask

    task automatic idle_rx(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clk);
            rx_valid = 1'b0;
            chk("idle_rx_no_rsp", 32'(rsp_valid), 32'd0);
            chk("idle_rx_no_timeout", 32'(rsp_timeout), 32'd0);
            chk("idle_rx_ready", 32'(cmd_ready), 32'd1);
            chk("idle_rx_rsp_data", 32'(rsp_data), 32'(last_rsp));
        end
    endtask

    task automatic run_txn(input vec_t v);
        int         got, guard, stall_left, need, k;
        logic       have_prev, seen_rv;
        logic [7:0] prev;
        need  = (v.ct == 2'd0) ? 0 : ((v.ct == 2'd1) ? 1 : 2);
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_type = v.ct; cmd_addr = v.addr; cmd_data = v.data;
        cmd_opa = v.opa; cmd_opb = v.opb; cmd_fun = v.fun;
        @(negedge clk);
        // Scramble the request fields to show the command was latched.
        cmd_valid = 1'b0; cmd_type = 2'($urandom); cmd_addr = 4'($urandom);
        cmd_data = 8'($urandom); cmd_opa = 8'($urandom); cmd_opb = 8'($urandom);
        cmd_fun = 4'($urandom);
        chk("cmd_ready_drop", 32'(cmd_ready), 32'd0);
        chk("tx_first_valid", 32'(tx_valid), 32'd1);

        got = 0; guard = 0; stall_left = v.stall_n; have_prev = 1'b0; prev = 8'h00;
        forever begin
            rx_valid = v.spur && ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            if (tx_valid) begin
                if (have_prev) chk("tx_hold", 32'(tx_data), 32'(prev));
                if (got == v.stall_idx && stall_left > 0) begin
                    stall_left--;
                    tx_ready = 1'b0; have_prev = 1'b1; prev = tx_data;
                end else if (v.rand_stall && $urandom_range(0, 2) == 0) begin
                    tx_ready = 1'b0; have_prev = 1'b1; prev = tx_data;
                end else begin
                    tx_ready = 1'b1; have_prev = 1'b0;
                    chk("tx_byte", 32'(tx_data), 32'(v.ef[got]));
                    got++;
                end
            end else begin
                if (have_prev) chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                tx_ready  = 1'($urandom);
                have_prev = 1'b0;
            end
            if (got >= v.exp_len) break;
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                chk("tx_bytes_timeout", 32'(got), 32'(v.exp_len));
                break;
            end
        end
        @(negedge clk);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        chk("tx_valid_after_frame", 32'(tx_valid), 32'd0);
        chk("cmd_ready_after_frame", 32'(cmd_ready), 32'(need == 0));
        chk("no_rsp_during_frame", 32'(rsp_valid), 32'd0);

        for (int b = 0; b < v.n_rx; b++) begin
            repeat ((b == 0) ? v.gap0 : v.gap1) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = (b == 0) ? v.rx0 : v.rx1;
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end

        if (v.exp_rsp) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_data", 32'(rsp_data), 32'(v.exp_data));
            chk("rsp_no_timeout", 32'(rsp_timeout), 32'd0);
            chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
            last_rsp = v.exp_data;
            @(negedge clk);
            chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
            chk("rsp_data_hold", 32'(rsp_data), 32'(v.exp_data));
        end else if (v.exp_to) begin
            seen_rv = 1'b0;
            for (k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (rsp_valid) seen_rv = 1'b1;
                if (rsp_timeout) break;
            end
            chk("timeout_delay", 32'(k), 32'(TO_CYC));
            chk("timeout_no_rsp", 32'(seen_rv), 32'd0);
            chk("timeout_rsp_data", 32'(rsp_data), 32'(last_rsp));
            chk("cmd_ready_after_timeout", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            chk("timeout_pulse", 32'(rsp_timeout), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, guard, need;
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 4'h0; cmd_data = 8'h00;
        cmd_opa = 8'h00; cmd_opb = 8'h00; cmd_fun = 4'h0; tx_ready = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        rst = 1'b0;
        idle_rx(3);

        //            ct    addr   data   opa    opb    fun  sidx sn rs sp nrx rx0    rx1   g0 g1 len ef            rsp data      to
        vecs[0] = mk(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, -1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 3, 32'h005A03AA, 0, 16'h0000, 0);
        vecs[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0,  1, 5, 0, 1, 1, 8'h7E, 8'h00, 2, 0, 2, 32'h000002BB, 1, 16'h007E, 0);
        vecs[2] = mk(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0, -1, 0, 0, 0, 2, 8'h30, 8'h00, 0, 3, 4, 32'h002010CC, 1, 16'h0030, 0);
        vecs[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, -1, 0, 0, 0, 1, 8'h55, 8'h00, 1, 0, 2, 32'h000002DD, 0, 16'h0000, 1);
        vecs[4] = mk(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 0, 1, 1, 8'hA5, 8'h00, 15, 0, 2, 32'h00000FBB, 1, 16'h00A5, 0);
        vecs[5] = mk(2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, -1, 0, 1, 1, 2, 8'h12, 8'h34, 15, 15, 4, 32'h0F01FFCC, 1, 16'h3412, 0);
        vecs[6] = mk(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 2, 32'h000007BB, 0, 16'h0000, 1);
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
            idle_rx(1);
        end

        // Reset while the third ALU byte is on the TX port.
        cmd_valid = 1'b1; cmd_type = 2'd2; cmd_opa = 8'h11; cmd_opb = 8'h22; cmd_fun = 4'h3;
        @(negedge clk);
        cmd_valid = 1'b0;
        tx_ready  = 1'b1;
        acc = 0; guard = 0;
        while (acc < 2 && guard < 50) begin
            if (tx_valid && tx_ready) acc++;
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_setup", 32'(acc), 32'd2);
        tx_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
        chk("pre_rst_tx_data", 32'(tx_data), 32'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        last_rsp = 16'h0000;
        run_txn(mk(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 0, 0, 1, 8'hC3, 8'h00, 4, 0,
                   2, 32'h000009BB, 1, 16'h00C3, 0));

        for (int it = 0; it < 30; it++) begin
            rv = mk(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    4'($urandom), -1, 0, 1, 1, 0, 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'(TO_CYC - 1) : $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? int'(TO_CYC - 1) : $urandom_range(0, 4),
                    0, 32'h0, 0, 16'h0, 0);
            need    = (rv.ct == 2'd0) ? 0 : ((rv.ct == 2'd1) ? 1 : 2);
            rv.n_rx = (need > 0 && $urandom_range(0, 4) == 0) ? need - 1 : need;
            model(rv);
            run_txn(rv);
            if ($urandom_range(0, 2) == 0) idle_rx(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
